// File: rtl/branch_predict_fetch_pkg.sv
// Shared constants and BHT counter encodings for the fetch-side branch predictor.
// Used by branch_predict_fetch and bpu_btb.
package branch_predict_fetch_pkg;

    localparam int WORD = 32;
    localparam logic [WORD-1:0] DEFAULT_RESET_PC = 32'h1c000000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bht_state_t;

    // Saturating 2-bit counter step toward the resolved direction.
    function automatic logic [1:0] bht_next(input logic [1:0] cnt, input logic taken);
        if (taken) begin
            return (cnt == ST) ? cnt : cnt + 2'd1;
        end
        return (cnt == SNT) ? cnt : cnt - 2'd1;
    endfunction

endpackage

// File: rtl/branch_predict_fetch_btb.sv
// bpu_btb: direct-mapped branch target buffer with a combinational read port,
// a synchronous write port and synchronously reset valid bits.
module bpu_btb
    import branch_predict_fetch_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int TAG_W   = 8,
    localparam int IDX_W  = $clog2(ENTRIES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [IDX_W-1:0]  rd_idx,
    input  logic [TAG_W-1:0]  rd_tag,
    output logic              hit,
    output logic [WORD-1:0]   rd_target,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [TAG_W-1:0]  wr_tag,
    input  logic [WORD-1:0]   wr_target
);

    logic [ENTRIES-1:0] valid;
    logic [TAG_W-1:0]   tags    [ENTRIES];
    logic [WORD-1:0]    targets [ENTRIES];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
        end else if (wr_en) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Tag/target storage carries no reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en && !rst) begin
            tags[wr_idx]    <= wr_tag;
            targets[wr_idx] <= wr_target;
        end
    end

    assign hit       = valid[rd_idx] && (tags[rd_idx] == rd_tag);
    assign rd_target = targets[rd_idx];

endmodule

// File: rtl/branch_predict_fetch.sv
// Fetch PC register with a 2-bit-counter BHT and direct-mapped BTB trained from EX.
// Define BPU_GSHARE_EN to XOR a non-speculative global history into the BHT index.
module branch_predict_fetch
    import branch_predict_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = DEFAULT_RESET_PC,
    parameter int          BHT_ENTRIES = 64,
    parameter int          BTB_ENTRIES = 16,
    parameter int          TAG_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        EX_Branch_out,
    input  logic [31:0] EX_PC_out,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    output logic [31:0] PC_IF,
    output logic        predict,
    output logic [31:0] pred_target
);

    localparam int BHT_IDX_W = $clog2(BHT_ENTRIES);
    localparam int BTB_IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_LSB   = BTB_IDX_W + 2;

    logic [1:0]           bht [BHT_ENTRIES];
    logic [BHT_IDX_W-1:0] bht_rd_idx;
    logic [BHT_IDX_W-1:0] bht_wr_idx;
    logic                 btb_hit;
    logic [31:0]          btb_target;
    logic                 unused_upd_bits;

    assign unused_upd_bits = ^upd_pc;

`ifdef BPU_GSHARE_EN
    logic [BHT_IDX_W-1:0] ghr;

    // History is shifted on the same edge as the counter update, which reads the old value.
    always_ff @(posedge clk) begin
        if (rst) begin
            ghr <= '0;
        end else if (upd_valid) begin
            ghr <= {ghr[BHT_IDX_W-2:0], upd_taken};
        end
    end

    assign bht_rd_idx = PC_IF[BHT_IDX_W+1:2] ^ ghr;
    assign bht_wr_idx = upd_pc[BHT_IDX_W+1:2] ^ ghr;
`else
    assign bht_rd_idx = PC_IF[BHT_IDX_W+1:2];
    assign bht_wr_idx = upd_pc[BHT_IDX_W+1:2];
`endif

    bpu_btb #(
        .ENTRIES(BTB_ENTRIES),
        .TAG_W  (TAG_W)
    ) u_btb (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (PC_IF[BTB_IDX_W+1:2]),
        .rd_tag   (PC_IF[TAG_LSB+TAG_W-1:TAG_LSB]),
        .hit      (btb_hit),
        .rd_target(btb_target),
        .wr_en    (upd_valid && upd_taken),
        .wr_idx   (upd_pc[BTB_IDX_W+1:2]),
        .wr_tag   (upd_pc[TAG_LSB+TAG_W-1:TAG_LSB]),
        .wr_target(upd_target)
    );

    assign predict     = btb_hit && bht[bht_rd_idx][1];
    assign pred_target = predict ? btb_target : PC_IF + 32'd4;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= WNT;
            end
        end else if (upd_valid) begin
            bht[bht_wr_idx] <= bht_next(bht[bht_wr_idx], upd_taken);
        end
    end

    // A redirect from EX outranks a fetch stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            PC_IF <= RESET_PC;
        end else if (EX_Branch_out) begin
            PC_IF <= EX_PC_out;
        end else if (!stall) begin
            PC_IF <= pred_target;
        end
    end

endmodule

// File: tb/tb_branch_predict_fetch.sv
// Scoreboard bench for branch_predict_fetch: a behavioural model predicts outputs and next PC.
// Honours BPU_GSHARE_EN when the design is built with it.
module tb_branch_predict_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        EX_Branch_out;
    logic [31:0] EX_PC_out;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic [31:0] PC_IF;
    logic        predict;
    logic [31:0] pred_target;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_q [$];

    logic [1:0]  m_bht   [64];
    logic        m_valid [16];
    logic [7:0]  m_tag   [16];
    logic [31:0] m_tgt   [16];
    logic [31:0] m_pc;
    logic [5:0]  m_ghr;

    logic [31:0] pool [4];

    branch_predict_fetch dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .EX_Branch_out(EX_Branch_out),
        .EX_PC_out    (EX_PC_out),
        .upd_valid    (upd_valid),
        .upd_pc       (upd_pc),
        .upd_taken    (upd_taken),
        .upd_target   (upd_target),
        .PC_IF        (PC_IF),
        .predict      (predict),
        .pred_target  (pred_target)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int i = 0; i < 64; i++) m_bht[i] = 2'b01;
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_pc  = 32'h1c000000;
        m_ghr = 6'd0;
    endtask

    // Drive one cycle at the negedge, check lookup outputs, queue the expected next PC,
    // advance the model, and compare PC_IF after the edge.
    task automatic applyStimulus(input string tag, input bit r, input bit st, input bit br,
                                 input logic [31:0] brpc, input bit uv, input logic [31:0] upc,
                                 input bit ut, input logic [31:0] utgt);
        logic [5:0]  li, ui;
        logic [3:0]  bi, wi;
        logic        ehit, epred;
        logic [31:0] etgt, enext;
        rst = r; stall = st; EX_Branch_out = br; EX_PC_out = brpc;
        upd_valid = uv; upd_pc = upc; upd_taken = ut; upd_target = utgt;
        #1;
        li    = m_pc[7:2] ^ m_ghr;
        bi    = m_pc[5:2];
        ehit  = m_valid[bi] && (m_tag[bi] == m_pc[13:6]);
        epred = ehit && m_bht[li][1];
        etgt  = epred ? m_tgt[bi] : m_pc + 32'd4;
        checkOutput($sformatf("%s.pred", tag), {31'd0, predict}, {31'd0, epred});
        checkOutput($sformatf("%s.tgt", tag), pred_target, etgt);
        enext = r ? 32'h1c000000 : (br ? brpc : (st ? m_pc : etgt));
        exp_q.push_back(enext);
        if (r) begin
            modelReset();
        end else begin
            m_pc = enext;
            if (uv) begin
                ui = upc[7:2] ^ m_ghr;
                if (ut && m_bht[ui] != 2'b11) m_bht[ui] = m_bht[ui] + 2'd1;
                else if (!ut && m_bht[ui] != 2'b00) m_bht[ui] = m_bht[ui] - 2'd1;
                if (ut) begin
                    wi = upc[5:2];
                    m_valid[wi] = 1'b1;
                    m_tag[wi]   = upc[13:6];
                    m_tgt[wi]   = utgt;
                end
`ifdef BPU_GSHARE_EN
                m_ghr = {m_ghr[4:0], ut};
`endif
            end
        end
        @(posedge clk);
        #1;
        checkOutput($sformatf("%s.pc", tag), PC_IF, exp_q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        pool[0] = 32'h1c000010;
        pool[1] = 32'h1c000410;
        pool[2] = 32'h1c000020;
        pool[3] = 32'h1c000100;
        rst = 1'b1; stall = 1'b0; EX_Branch_out = 1'b0; EX_PC_out = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst.pc", PC_IF, 32'h1c000000);
        checkOutput("rst.pred", {31'd0, predict}, 32'd0);
        checkOutput("rst.tgt", pred_target, 32'h1c000004);

        for (int i = 0; i < 4; i++) begin
            applyStimulus($sformatf("seq%0d", i), 0, 0, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("seq%0d.const", i), PC_IF, 32'h1c000004 + 32'(i) * 32'd4);
        end

        applyStimulus("train0", 0, 1, 0, 0, 1, 32'h1c000010, 1, 32'h1c000100);
        applyStimulus("train1", 0, 1, 0, 0, 1, 32'h1c000010, 1, 32'h1c000100);
`ifndef BPU_GSHARE_EN
        checkOutput("trained.pred", {31'd0, predict}, 32'd1);
        checkOutput("trained.tgt", pred_target, 32'h1c000100);
`endif
        applyStimulus("taken", 0, 0, 0, 0, 0, 0, 0, 0);
`ifndef BPU_GSHARE_EN
        checkOutput("taken.const", PC_IF, 32'h1c000100);
`endif
        applyStimulus("nt0", 0, 1, 1, 32'h1c000010, 1, 32'h1c000010, 0, 0);
        checkOutput("redir.const", PC_IF, 32'h1c000010);
`ifndef BPU_GSHARE_EN
        checkOutput("collide.old", {31'd0, predict}, 32'd1);
`endif
        applyStimulus("nt1", 0, 1, 0, 0, 1, 32'h1c000010, 0, 0);
`ifndef BPU_GSHARE_EN
        checkOutput("collide.new", {31'd0, predict}, 32'd0);
`endif

        applyStimulus("stallredir", 0, 1, 1, 32'h1c000200, 0, 0, 0, 0);
        checkOutput("stallredir.const", PC_IF, 32'h1c000200);
        for (int i = 0; i < 3; i++) begin
            applyStimulus($sformatf("hold%0d", i), 0, 1, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("hold%0d.const", i), PC_IF, 32'h1c000200);
        end

        applyStimulus("wrapgo", 0, 0, 1, 32'hfffffffc, 0, 0, 0, 0);
        applyStimulus("wrap", 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("wrap.const", PC_IF, 32'h00000000);

        applyStimulus("rstupd", 1, 0, 0, 0, 1, 32'h1c000000, 1, 32'h1c000300);
        applyStimulus("rstupd.after", 0, 1, 0, 0, 0, 0, 0, 0);
        checkOutput("rstupd.pred", {31'd0, predict}, 32'd0);

        for (int i = 0; i < 60; i++) begin
            applyStimulus($sformatf("rnd%0d", i), 0,
                          $urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
                          pool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
                          pool[$urandom_range(0, 3)], $urandom_range(0, 1) == 1,
                          pool[$urandom_range(0, 3)]);
        end

`ifdef BPU_GSHARE_EN
        applyStimulus("g.rst", 1, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus("g0", 0, 1, 0, 0, 1, 32'h1c000010, 1, 32'h1c000100);
        applyStimulus("g1", 0, 1, 0, 0, 1, 32'h1c000410, 1, 32'h1c000100);
        applyStimulus("g2", 0, 1, 0, 0, 1, 32'h1c000010, 0, 0);
        checkOutput("ghr", {26'd0, dut.ghr}, 32'b000110);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/branch_predict_fetch.md
Name: branch_predict_fetch

Overview:
- Fetch-side counterpart of the EX branch-resolution path.
- Owns the fetch PC register and generates the `predict` bit that travels down the pipe with each instruction.
- Trains a 2-bit-counter BHT and a direct-mapped BTB from resolved branches reported by EX.
- Consumes the EX redirect (EX_Branch_out / EX_PC_out) to restart fetch after a misprediction.

Parameters:
- RESET_PC, 32'h1c000000, fetch address after reset.
- BHT_ENTRIES, 64, number of 2-bit counters (power of 2).
- BTB_ENTRIES, 16, number of BTB entries (power of 2).
- TAG_W, 8, BTB tag bits taken above the BTB index.

Ports:
- clk  in  1  clock.
- rst  in  1  reset.
- stall  in  1  hold fetch PC (IF stall from hazard unit).
- EX_Branch_out  in  1  EX redirect request (misprediction).
- EX_PC_out  in  32  correct next PC from EX.
- upd_valid  in  1  EX has a resolved branch this cycle.
- upd_pc  in  32  PC of the resolved branch.
- upd_taken  in  1  actual direction.
- upd_target  in  32  actual taken target.
- PC_IF  out  32  current fetch PC.
- predict  out  1  predicted-taken flag for the instruction at PC_IF.
- pred_target  out  32  predicted next PC.

Behaviour:
- Reset is synchronous and active-high on `rst`, sampled on the posedge of the single clock `clk`.
- Reset values:
  - PC_IF = RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - All BTB valid bits = 0.
  - predict = 0; pred_target = RESET_PC+4, both purely combinational from reset state.
- Lookup is combinational on PC_IF, zero latency:
  - bht_idx = PC_IF[log2(BHT_ENTRIES)+1:2].
  - btb_idx = PC_IF[log2(BTB_ENTRIES)+1:2].
  - tag = next TAG_W bits above btb_idx.
  - hit = valid[btb_idx] && tag match.
  - predict = hit && bht[bht_idx][1].
  - pred_target = predict ? btb_target[btb_idx] : PC_IF+4.
- Next-PC priority at the clock edge:
  1. rst: PC_IF <= RESET_PC.
  2. EX_Branch_out: PC_IF <= EX_PC_out. Overrides stall.
  3. stall: PC_IF holds.
  4. otherwise: PC_IF <= pred_target.
- Update at the clock edge when upd_valid:
  - BHT counter at upd_pc index saturates: +1 if taken (max 2'b11), -1 if not taken (min 2'b00).
  - If taken: BTB entry at upd_pc index <= {valid=1, tag, upd_target}.
  - Not-taken updates never touch the BTB.
- Update is independent of stall and redirect. Updates still occur during stall and in the same cycle as a redirect.
- Read/write collision on the same index: the lookup returns the pre-update value (no bypass). The new value is visible the following cycle.
- Reset asserted mid-update: reset wins and the update is discarded.
- PC+4 wraps modulo 2^32. PC bits [1:0] are ignored for indexing.

Optional Feature:
- Macro: BPU_GSHARE_EN.
- Defined:
  - Adds a GHR of log2(BHT_ENTRIES) bits, reset to 0.
  - Lookup index = PC_IF[...:2] XOR GHR.
  - Update index = upd_pc[...:2] XOR GHR_at_update.
  - On each upd_valid, GHR shifts left by one bit with upd_taken inserted at bit 0. The shift happens in the same edge as the counter update, and the counter update uses the pre-shift GHR.
  - GHR is trained non-speculatively (EX only).
- Not defined:
  - Pure bimodal PC indexing; no GHR flops exist.

Decomposition:
- Shared header CPU_Parameter.vh gets:
  - `WORD`.
  - `RESET_PC`.
  - BHT counter encodings: SNT=2'b00, WNT=2'b01, WT=2'b10, ST=2'b11.
- One sub-module, bpu_btb:
  - Direct-mapped valid/tag/target arrays.
  - Combinational read port and synchronous write port.
  - Synchronous reset of the valid bits.
- BHT and next-PC logic stay in the top module.

Test Plan:
- Reset then run 4 cycles, no stall -> PC_IF = 1c000000, 1c000004, 1c000008, 1c00000c; predict=0 throughout.
- Train 1c000010 taken to 1c000100 twice (upd_valid, upd_taken=1) -> counter 01 -> 10 -> 11. When PC_IF=1c000010: predict=1, next PC_IF=1c000100.
- Same branch, two not-taken updates -> counter drops to 01. Then predict=0 at 1c000010 even though the BTB hit stays valid.
- stall=1 and EX_Branch_out=1 with EX_PC_out=1c000200 in the same cycle -> next PC_IF=1c000200. With stall=1 alone, PC_IF holds for 3 cycles.
- Update of index k in the same cycle PC_IF looks up index k -> predict reflects the old counter that cycle and the new counter the next cycle.
- BPU_GSHARE_EN: updates taken, taken, not-taken -> GHR=6'b000110. Two branches aliasing in bimodal mode map to distinct counters under gshare.
